// File: rtl/tone_pkg.sv
// Shared types and default constants for the tone detector.
// Defaults match the buzzer generator divider range 0x2000..0x3FC0.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_MIN_HALF = 8192;
  localparam int unsigned DEF_MAX_HALF = 16384;
  localparam int unsigned DEF_TOL      = 128;
  localparam int unsigned DEF_LOCK_N   = 4;
  localparam int unsigned DEF_TIMEOUT  = 32768;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/tone_sync.sv
// 2-FF synchronizer plus delay flop; registered strobe on any input transition.
// Strobe appears 2 edges after the input is first sampled; free-running, no enable, no backpressure.
module tone_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic edge_stb
);

  logic [2:0] sync_q, sync_d;
  logic       edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[1:0], tone_in};
    edge_d = sync_q[1] ^ sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign edge_stb = edge_q;

endmodule

// File: rtl/tone_detector.sv
// Half-period meter with pitch-window lock; outputs register 3 cycles after an input transition, no backpressure.
// Optional sweep-direction strobes when TONE_DET_SWEEP_EN is defined.
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MIN_HALF = DEF_MIN_HALF,
  parameter int unsigned MAX_HALF = DEF_MAX_HALF,
  parameter int unsigned TOL      = DEF_TOL,
  parameter int unsigned LOCK_N   = DEF_LOCK_N,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tone_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             tone_present,
  output logic             sweep_up,
  output logic             sweep_down
);

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_N);

  logic             edge_stb;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, prev_q, prev_d, half_q, half_d, diff;
  logic [3:0]       good_q, good_d;
  logic             prev_vld_q, prev_vld_d, pv_q, pv_d, present_q, present_d, meas_ok;
`ifdef TONE_DET_SWEEP_EN
  logic             up_q, up_d, down_q, down_d;
`endif

  tone_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .tone_in  (tone_in),
    .edge_stb (edge_stb)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    good_d     = good_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    half_d     = half_q;
    pv_d       = 1'b0;
`ifdef TONE_DET_SWEEP_EN
    up_d       = 1'b0;
    down_d     = 1'b0;
`endif
    diff    = (cnt_q >= prev_q) ? cnt_q - prev_q : prev_q - cnt_q;
    meas_ok = (cnt_q >= MIN_C) && (cnt_q <= MAX_C) && (!prev_vld_q || diff <= TOL_C);

    if (edge_stb)                cnt_d = CNT_W'(1);
    else if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + 1'b1;

    // An edge takes priority over a coincident timeout.
    if (edge_stb) begin
      if (state_q == IDLE) begin
        state_d = MEASURE;
        good_d  = '0;
      end else begin
        half_d     = cnt_q;
        pv_d       = 1'b1;
        prev_d     = cnt_q;
        prev_vld_d = 1'b1;
        if (!meas_ok) begin
          state_d = MEASURE;
          good_d  = '0;
        end else if (state_q == MEASURE) begin
          good_d = sat_inc4(good_q, LOCK_C);
          if (good_d == LOCK_C) state_d = LOCKED;
        end else begin
`ifdef TONE_DET_SWEEP_EN
          up_d   = cnt_q < prev_q;
          down_d = cnt_q > prev_q;
`endif
        end
      end
    end else if (cnt_q == TIMEOUT_C) begin
      state_d    = IDLE;
      good_d     = '0;
      prev_vld_d = 1'b0;
    end

    present_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      good_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      half_q     <= '0;
      pv_q       <= 1'b0;
      present_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      half_q     <= half_d;
      pv_q       <= pv_d;
      present_q  <= present_d;
    end
  end

`ifdef TONE_DET_SWEEP_EN
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= up_d;
      down_q <= down_d;
    end
  end

  assign sweep_up   = up_q;
  assign sweep_down = down_q;
`else
  assign sweep_up   = 1'b0;
  assign sweep_down = 1'b0;
`endif

  assign half_period  = half_q;
  assign period_valid = pv_q;
  assign tone_present = present_q;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector with scaled-down window parameters; a spec-level model queues
// the expected strobe for every driven input transition and the monitor compares on period_valid.
module tb_tone_detector;

  localparam int CNT_W    = 16;
  localparam int MIN_HALF = 100;
  localparam int MAX_HALF = 200;
  localparam int TOL      = 8;
  localparam int LOCK_N   = 4;
  localparam int TIMEOUT  = 400;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             period_valid, tone_present, sweep_up, sweep_down;

  always #5 clk = ~clk;

  tone_detector #(
    .CNT_W(CNT_W), .MIN_HALF(MIN_HALF), .MAX_HALF(MAX_HALF),
    .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .tone_in      (tone_in),
    .half_period  (half_period),
    .period_valid (period_valid),
    .tone_present (tone_present),
    .sweep_up     (sweep_up),
    .sweep_down   (sweep_down)
  );

  typedef struct {
    int half;
    bit present;
    bit up;
    bit down;
  } exp_t;

  typedef struct {
    int iv;
    int n;
    bit lock;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_tog = 0;
  int   last_pv_cyc = 0;
  int   m_st, m_good, m_prev;
  bit   m_pv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    if (period_valid) begin
      last_pv_cyc = cyc;
      if (sb_q.size() == 0) begin
        check("strobe_expected", 0, 1);
      end else begin
        mon_e = sb_q.pop_front();
        check("half_period", int'(half_period), mon_e.half);
        check("tone_present_at_strobe", int'(tone_present), int'(mon_e.present));
        check("sweep_up", int'(sweep_up), int'(mon_e.up));
        check("sweep_down", int'(sweep_down), int'(mon_e.down));
      end
    end else if (sweep_up || sweep_down) begin
      check("sweep_needs_valid", int'(period_valid), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_st = 0; m_good = 0; m_prev = 0; m_pv = 0;
  endtask

  // Reference behaviour: 0 idle, 1 measuring, 2 locked.
  task automatic model_edge(input int iv);
    exp_t e;
    bit   ok;
    int   d;
    if (iv > TIMEOUT) begin
      m_st = 0; m_good = 0; m_pv = 0;
    end
    if (m_st == 0) begin
      m_st = 1; m_good = 0;
      return;
    end
    d  = (iv > m_prev) ? iv - m_prev : m_prev - iv;
    ok = (iv >= MIN_HALF) && (iv <= MAX_HALF) && (!m_pv || d <= TOL);
    e.up = 0; e.down = 0;
    if (!ok) begin
      m_st = 1; m_good = 0;
    end else if (m_st == 1) begin
      if (m_good < LOCK_N) m_good++;
      if (m_good == LOCK_N) m_st = 2;
    end else begin
`ifdef TONE_DET_SWEEP_EN
      e.up   = iv < m_prev;
      e.down = iv > m_prev;
`endif
    end
    m_prev = iv; m_pv = 1;
    e.half = iv;
    e.present = (m_st == 2);
    sb_q.push_back(e);
  endtask

  task automatic toggle_after(input int iv);
    int el;
    while (cyc - last_tog < iv) tick(1);
    el = cyc - last_tog;
    tone_in = ~tone_in;
    last_tog = cyc;
    model_edge(el);
  endtask

  task automatic drive(input int iv, input int n);
    for (int i = 0; i < n; i++) toggle_after(iv);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tone_in = 1'b0;
    tick(n);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string name);
    tick(6);
    check(name, sb_q.size(), 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_half_period"}, int'(half_period), 0);
    check({pfx, "_period_valid"}, int'(period_valid), 0);
    check({pfx, "_tone_present"}, int'(tone_present), 0);
    check({pfx, "_sweep_up"}, int'(sweep_up), 0);
    check({pfx, "_sweep_down"}, int'(sweep_down), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t win[4];
    int   fall;
    win[0] = '{iv: 99,  n: 8, lock: 1'b0};
    win[1] = '{iv: 100, n: 8, lock: 1'b1};
    win[2] = '{iv: 200, n: 8, lock: 1'b1};
    win[3] = '{iv: 201, n: 8, lock: 1'b0};

    // Reset state and lock timing
    do_reset(3);
    check_zero("reset");
    drive(150, 4);
    tick(4);
    check("no_lock_after_4_edges", int'(tone_present), 0);
    drive(150, 1);
    tick(4);
    check("lock_on_5th_edge", int'(tone_present), 1);
    drain("drain_basic");

    // Pitch window boundaries
    foreach (win[i]) begin
      do_reset(3);
      drive(win[i].iv, win[i].n);
      drain($sformatf("drain_win_%0d", win[i].iv));
      check($sformatf("window_lock_%0d", win[i].iv), int'(tone_present), int'(win[i].lock));
    end

    // Sweep strobes, equal period, then a jump beyond tolerance
    do_reset(3);
    drive(150, 5);
    drive(155, 1);
    drive(147, 1);
    drive(147, 1);
    drive(160, 1);
    drain("drain_sweep");
    check("jump_drops_lock", int'(tone_present), 0);
    drive(160, 3);
    drain("drain_after_jump");
    check("measure_not_idle_after_jump", int'(tone_present), 0);
    drive(160, 1);
    drain("drain_relock_jump");
    check("relock_after_jump", int'(tone_present), 1);

    // Silence: lock falls TIMEOUT cycles after the last strobe
    tick(10);
    fall = 0;
    for (int i = 0; i < 2 * TIMEOUT && tone_present; i++) begin
      tick(1);
      fall = cyc;
    end
    check("silence_fall_delay", fall - last_pv_cyc, TIMEOUT);
    check("silence_no_lock", int'(tone_present), 0);

    // Edge coincident with timeout is measured; one cycle later it is an idle edge
    drive(150, 2);
    toggle_after(TIMEOUT);
    toggle_after(TIMEOUT + 1);
    drive(150, 4);
    drain("drain_timeout_edges");
    check("relock_after_timeout_edges", int'(tone_present), 1);

    // Reset pulse while locked and mid-count
    tick(70);
    rst = 1'b1;
    tone_in = 1'b0;
    tick(1);
    rst = 1'b0;
    model_reset();
    check_zero("midreset");
    drive(150, 4);
    drain("drain_midreset");
    check("midreset_not_locked_yet", int'(tone_present), 0);
    drive(150, 1);
    drain("drain_midreset_lock");
    check("midreset_relock", int'(tone_present), 1);

    // Disable mid-operation
    tick(50);
    enable = 1'b0;
    tick(10);
    check_zero("disable");
    enable = 1'b1;
    model_reset();
    drive(150, 5);
    drain("drain_disable");
    check("disable_relock", int'(tone_present), 1);

    // Generator-style sweep in steps within tolerance
    do_reset(3);
    drive(100, 5);
    for (int iv = 104; iv <= 196; iv += 4) drive(iv, 1);
    for (int iv = 192; iv >= 100; iv -= 4) drive(iv, 1);
    drain("drain_gen_sweep");
    check("gen_sweep_lock_held", int'(tone_present), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tone_detector.md
# tone_detector

Receive-side counterpart of the buzzer tone generator. Measures the half-period of an incoming square wave on `tone_in` (e.g. loop-back of the buzzer drive, or a comparator-squared microphone), qualifies it against a pitch window, and reports lock and, optionally, sweep direction. Sits between the pin/synchronizer boundary and game/self-test logic that needs to confirm that the beeper is actually sounding.

## Interface
- `CNT_W`, 16: width of the half-period counter and of `half_period`.
- `MIN_HALF`, 8192: smallest accepted half-period, in clk cycles, inclusive.
- `MAX_HALF`, 16384: largest accepted half-period, in clk cycles, inclusive.
- `TOL`, 128: maximum accepted |current − previous| half-period difference.
- `LOCK_N`, 4: consecutive good measurements required for lock; 1..15.
- `TIMEOUT`, 32768: cycles with no edge before the input is declared silent; must be < 2^CNT_W and > MAX_HALF.
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous, active-high.
- `enable` in 1: detector enable; low behaves as reset, except the synchronizer keeps sampling.
- `tone_in` in 1: asynchronous square-wave input.
- `half_period` out CNT_W: last measured half-period in cycles; held between updates.
- `period_valid` out 1: one-cycle strobe when `half_period` updates.
- `tone_present` out 1: high while locked.
- `sweep_up` out 1: one-cycle strobe, period decreased (pitch rising); see Configuration.
- `sweep_down` out 1: one-cycle strobe, period increased (pitch falling); see Configuration.

## Operation
- Front end: 2-FF synchronizer, then a third flop. An edge strobe occurs on any transition, i.e. when sync2 differs from the third flop.
- Counter `cnt`:
  - Cleared to 1 on an edge strobe; otherwise increments.
  - Saturates at TIMEOUT.
  - The measurement m is the `cnt` value at the edge strobe, which equals the clk cycles between consecutive strobes. A generator toggling every D+1 cycles yields m = D+1.
- States:
  - IDLE:
    - First edge → MEASURE, clear `good`, no strobe.
    - No measurement exists yet.
  - MEASURE, on each edge:
    - Register m into `half_period`, pulse `period_valid`.
    - m is good if MIN_HALF ≤ m ≤ MAX_HALF and |m − prev| ≤ TOL.
    - If the previous measurement was absent, only the range test applies.
    - Good increments `good`; bad clears it.
    - When `good` reaches LOCK_N → LOCKED.
    - prev ← m always.
  - LOCKED, on each edge:
    - Update and strobe as in MEASURE.
    - Out-of-range m or jump > TOL → MEASURE, clear `good`.
    - Otherwise stay.
  - Any state: `cnt` reaching TIMEOUT → IDLE, clear `good`, prev invalid. No strobe is issued for the timeout.
- `tone_present` = (state == LOCKED), registered.
- Arithmetic:
  - The difference is computed unsigned as the larger minus the smaller, CNT_W bits; no overflow is possible.
  - `good` is 4 bits and saturates at LOCK_N.
- Simultaneous edge and timeout in the same cycle: the edge wins. The measurement is m = TIMEOUT, which is out of range, and the state goes to MEASURE.
- `rst` or `enable` low:
  - state IDLE, `cnt` 0, `good` 0, prev invalid.
  - All outputs 0, including `half_period`.
  - Reset mid-measurement discards the partial count.
  - On re-enable, the first edge is treated as the IDLE first edge.

## Timing
- A `tone_in` change first sampled at clk edge k produces the edge strobe at edge k+2.
- `period_valid`, `half_period`, `sweep_*` and the state update are registered at edge k+3. Latency from input transition to strobe is 3 cycles, ±1 for synchronizer metastability resolution.
- `tone_present` rises in the same cycle as the LOCK_N-th good `period_valid`.
- On timeout, `tone_present` falls at the edge after `cnt` reaches TIMEOUT.
- Throughput: one measurement per edge. Edges closer than 3 cycles apart are legal and measured, but are out of range.

## Configuration
- `TONE_DET_SWEEP_EN` defined:
  - In LOCKED only, a good edge with m < prev pulses `sweep_up`, and m > prev pulses `sweep_down`, coincident with `period_valid`.
  - m == prev pulses neither.
- Not defined: `sweep_up` and `sweep_down` are tied 0 and the comparator logic is omitted. All other behaviour is identical.

## Structure
- Shared package `tone_pkg` holds:
  - The state enum: IDLE, MEASURE, LOCKED.
  - Default constants for MIN_HALF, MAX_HALF, TOL, LOCK_N and TIMEOUT, matching the generator's divider range 0x2000..0x3FC0.
- One sub-module `tone_sync`: the 2-FF synchronizer plus the third flop and the edge strobe. Its output is sampled unconditionally and it has no enable.

## Test plan
- Reset state: hold `rst` 3 cycles, then `tone_in` toggling every 10000 cycles with `enable`=1:
  - After reset, all outputs are 0.
  - The 1st edge gives no strobe; the 2nd gives `half_period`=10000.
  - On the 5th edge, `tone_present` rises together with the 4th strobe.
- Window edges: with toggle interval 8191, `tone_present` never rises. With 8192 or 16384 it locks. With 16385 it never locks.
- Sweep: lock at 12000, then intervals 12064 and 11936:
  - With `TONE_DET_SWEEP_EN`, `sweep_down` then `sweep_up` pulse.
  - Without the macro, both stay 0.
  - A jump to 12500 drops `tone_present` and the state returns to MEASURE.
- Silence: lock, then freeze `tone_in`. `tone_present` falls 32768 cycles after the last strobe edge, and no `period_valid` is issued.
- Reset or disable mid-operation: assert `rst` for 1 cycle while locked and mid-count. All outputs read 0 the next cycle; the next edge gives no strobe; relock occurs after LOCK_N+1 edges.
- Generator loop-back: drive from the buzzer generator with a fast sweep:
  - Every `half_period` is in 8193..16321.
  - Lock holds across sweep steps of 64.
